// File: rtl/mac_lookup_arbiter.sv
// Round-robin arbiter sharing one single-read-port MAC table among NUM_PORTS ingress requesters.
// Each lookup runs IDLE -> WAIT -> RESP -> GAP; a miss is declared after TIMEOUT WAIT cycles.
module mac_lookup_arbiter #(
  parameter int NUM_PORTS = 8,
  parameter int MAC_WIDTH = 48,
  parameter int TIMEOUT   = 16,
  localparam int PW = $clog2(NUM_PORTS),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           req_valid,
  input  logic [NUM_PORTS*MAC_WIDTH-1:0] req_mac,
  output logic [NUM_PORTS-1:0]           req_ready,
  output logic [NUM_PORTS-1:0]           resp_valid,
  output logic [PW-1:0]                  resp_port,
  output logic                           resp_hit,
  output logic                           resp_drop,
  output logic                           tbl_read_en,
  output logic [MAC_WIDTH-1:0]           tbl_read_address,
  input  logic [PW-1:0]                  tbl_read_out,
  input  logic                           tbl_read_out_valid
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

  state_t               state;
  logic [PW-1:0]        grant;
  logic [PW-1:0]        last_grant;
  logic [CW-1:0]        cnt;
  logic [PW-1:0]        pick;
  logic [PW-1:0]        cand;
  logic                 found;
  logic [MAC_WIDTH-1:0] mac_arr [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_mac
    assign mac_arr[i] = req_mac[i*MAC_WIDTH +: MAC_WIDTH];
  end

  // Scan upward from last_grant+1 so the most recently served port has lowest priority.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((32'(last_grant) + i + 1) % NUM_PORTS);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      grant            <= '0;
      last_grant       <= PW'(NUM_PORTS - 1);
      cnt              <= '0;
      req_ready        <= '0;
      resp_valid       <= '0;
      resp_port        <= '0;
      resp_hit         <= 1'b0;
      resp_drop        <= 1'b0;
      tbl_read_en      <= 1'b0;
      tbl_read_address <= '0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            grant            <= pick;
            tbl_read_address <= mac_arr[pick];
            req_ready        <= NUM_PORTS'(1) << pick;
            tbl_read_en      <= 1'b1;
            cnt              <= '0;
            state            <= WAIT;
          end
        end
        WAIT: begin
          // cnt == 0 marks the first WAIT cycle, when the table's valid is not yet meaningful.
          if (cnt != '0 && tbl_read_out_valid) begin
            resp_hit    <= 1'b1;
            resp_port   <= tbl_read_out;
            resp_drop   <= (tbl_read_out == grant);
            resp_valid  <= NUM_PORTS'(1) << grant;
            tbl_read_en <= 1'b0;
            last_grant  <= grant;
            state       <= RESP;
          end else if (cnt == CW'(TIMEOUT)) begin
            resp_hit    <= 1'b0;
            resp_port   <= '0;
            resp_drop   <= 1'b0;
            resp_valid  <= NUM_PORTS'(1) << grant;
            tbl_read_en <= 1'b0;
            last_grant  <= grant;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: state <= GAP;
        GAP:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
